// File: rtl/wb_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// wb_cmd_master_pkg
// Shared types and response status codes for the Wishbone command initiator.
// Revision: 1.0
// ============================================================================
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_ERR       = 2'd1;
    localparam logic [1:0] ST_TIMEOUT   = 2'd2;
    localparam logic [1:0] ST_RETRY_EXH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// wb_cmd_master
// Wishbone classic initiator: one bus cycle per command with retry, timeout
// and a completion status returned on the response channel.
// Revision: 1.0
// ============================================================================
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]              rsp_status,

    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   C_TMO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]      C_RETRY_MAX = 4'(RETRY_MAX);

    state_t                  r_state;
    logic [TW-1:0]           r_tmo;
    logic [3:0]              r_retry;
    logic                    r_cyc;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [SELECT_WIDTH-1:0] r_sel;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_dat;
    logic [1:0]              r_rsp_status;

    // cyc and stb share one register, so termination qualifies on it alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_retry      <= '0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_we    <= cmd_we;
                        r_adr   <= cmd_adr;
                        r_dat   <= cmd_dat;
                        r_sel   <= cmd_sel;
                        r_tmo   <= '0;
                        r_retry <= '0;
                        r_cyc   <= 1'b1;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (r_cyc && wb_err_i) begin
                        r_cyc        <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= ST_ERR;
                        r_rsp_dat    <= '0;
                        r_state      <= S_RESP;
                    end else if (r_cyc && wb_ack_i) begin
                        r_cyc        <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= ST_OK;
                        r_rsp_dat    <= r_we ? '0 : wb_dat_i;
                        r_state      <= S_RESP;
                    end else if (r_cyc && wb_rty_i) begin
                        r_cyc <= 1'b0;
                        if (r_retry == C_RETRY_MAX) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_status <= ST_RETRY_EXH;
                            r_rsp_dat    <= '0;
                            r_state      <= S_RESP;
                        end else begin
                            r_retry <= r_retry + 4'd1;
                            r_state <= S_BACKOFF;
                        end
                    end else if (r_tmo == C_TMO_MAX) begin
                        r_cyc        <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= ST_TIMEOUT;
                        r_rsp_dat    <= '0;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    r_tmo   <= '0;
                    r_cyc   <= 1'b1;
                    r_state <= S_ACTIVE;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE) && rst;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;
    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign wb_sel_o   = r_sel;
    assign wb_we_o    = r_we;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_wb_cmd_master
// Directed vector bench with a configurable Wishbone slave model.
// Revision: 1.0
// ============================================================================
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    wb_cmd_master #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .SELECT_WIDTH   (4),
        .TIMEOUT_CYCLES (10),
        .RETRY_MAX      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_status (rsp_status),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i)
    );

    always #5 clk = ~clk;

    // Slave modes: 0 ack (after cfg_rty_n rty pulses), 1 silent, 2 err+ack, 3 rty forever, 4 ack+rty
    int cfg_mode  = 0;
    int cfg_wait  = 0;
    int cfg_rty_n = 0;
    int cfg_base  = 0;

    int          wcnt        = 0;
    int          mon_hi      = 0;
    int          mon_rise    = 0;
    int          done_pulses = 0;
    logic        mon_prev    = 1'b0;
    logic        cap_we      = 1'b0;
    logic [31:0] cap_adr     = '0;
    logic [31:0] cap_dat     = '0;
    logic [3:0]  cap_sel     = '0;

    always @(posedge clk) begin
        mon_prev <= wb_cyc_o;
        if (wb_cyc_o) begin
            mon_hi  <= mon_hi + 1;
            wcnt    <= wcnt + 1;
            cap_we  <= wb_we_o;
            cap_adr <= wb_adr_o;
            cap_dat <= wb_dat_o;
            cap_sel <= wb_sel_o;
            if (!mon_prev) mon_rise <= mon_rise + 1;
        end else begin
            wcnt <= 0;
        end
        if (!wb_cyc_o && mon_prev) done_pulses <= done_pulses + 1;
    end

    always_comb begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_cyc_o && wb_stb_o && wcnt == cfg_wait) begin
            case (cfg_mode)
                0: begin
                    if ((done_pulses - cfg_base) < cfg_rty_n) wb_rty_i = 1'b1;
                    else wb_ack_i = 1'b1;
                end
                2: begin wb_err_i = 1'b1; wb_ack_i = 1'b1; end
                3: wb_rty_i = 1'b1;
                4: begin wb_ack_i = 1'b1; wb_rty_i = 1'b1; end
                default: ;
            endcase
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          mode;
        int          wt;
        int          rty_n;
        logic [31:0] sdat;
        logic [1:0]  exp_st;
        logic [31:0] exp_rdat;
        int          exp_pulses;
        int          exp_hi;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    // Returns at the first falling edge after the accepting edge
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output bit ok);
        int g;
        @(negedge clk);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        ok = cmd_ready;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready never rose for adr 0x%0h", adr);
            cmd_valid = 1'b0;
        end else begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string tag, output int lat, output bit ok);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = rsp_valid;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s rsp_timeout: rsp_valid never asserted", tag);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  base_p, base_h, lat;
        bit  ok;
        base_p    = mon_rise;
        base_h    = mon_hi;
        cfg_base  = done_pulses;
        cfg_mode  = v.mode;
        cfg_wait  = v.wt;
        cfg_rty_n = v.rty_n;
        wb_dat_i  = v.sdat;
        send_cmd(v.we, v.adr, v.dat, v.sel, ok);
        if (!ok) return;
        wait_rsp(tag, lat, ok);
        if (!ok) return;
        chk({tag, " status"}, 64'(rsp_status), 64'(v.exp_st));
        chk({tag, " rsp_dat"}, 64'(rsp_dat), 64'(v.exp_rdat));
        chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, " pulses"}, 64'(mon_rise - base_p), 64'(v.exp_pulses));
        chk({tag, " cyc_cycles"}, 64'(mon_hi - base_h), 64'(v.exp_hi));
        chk({tag, " wb_we"}, 64'(cap_we), 64'(v.we));
        chk({tag, " wb_adr"}, 64'(cap_adr), 64'(v.adr));
        chk({tag, " wb_dat"}, 64'(cap_dat), 64'(v.dat));
        chk({tag, " wb_sel"}, 64'(cap_sel), 64'(v.sel));
        chk({tag, " cyc_low_at_rsp"}, 64'(wb_cyc_o), 64'd0);
        @(negedge clk);
        chk({tag, " rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  ok;
        logic [31:0] hold_dat;

        //                we    adr           dat           sel   md wt rn sdat          st    rdat          p  h   lat
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0015, 4'hF, 0, 0, 0, 32'h1234_5678, 2'd0, 32'h0000_0000, 1, 1,  2};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 0, 3, 0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 1, 4,  5};
        vecs[2] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 4'h3, 0, 0, 2, 32'hCAFE_F00D, 2'd0, 32'hCAFE_F00D, 3, 3,  6};
        vecs[3] = '{1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'hC, 3, 0, 0, 32'h1111_1111, 2'd3, 32'h0000_0000, 4, 4,  8};
        vecs[4] = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'hF, 1, 0, 0, 32'h2222_2222, 2'd2, 32'h0000_0000, 1, 11, 12};
        vecs[5] = '{1'b0, 32'h0000_0404, 32'h0000_0000, 4'hF, 0, 1, 0, 32'h0BAD_C0DE, 2'd0, 32'h0BAD_C0DE, 1, 2,  3};
        vecs[6] = '{1'b0, 32'h0000_0500, 32'h0000_0000, 4'hF, 2, 0, 0, 32'h3333_3333, 2'd1, 32'h0000_0000, 1, 1,  2};
        vecs[7] = '{1'b0, 32'h0000_0600, 32'h0000_0000, 4'hF, 4, 0, 0, 32'h4444_4444, 2'd0, 32'h4444_4444, 1, 1,  2};
        vecs[8] = '{1'b1, 32'h0000_0700, 32'h0000_5A5A, 4'h1, 2, 2, 0, 32'h5555_5555, 2'd1, 32'h0000_0000, 1, 3,  4};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst stb", 64'(wb_stb_o), 64'd0);
        chk("rst we", 64'(wb_we_o), 64'd0);
        chk("rst adr", 64'(wb_adr_o), 64'd0);
        chk("rst dat", 64'(wb_dat_o), 64'd0);
        chk("rst sel", 64'(wb_sel_o), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_dat", 64'(rsp_dat), 64'd0);
        chk("rst rsp_status", 64'(rsp_status), 64'd0);
        chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Response back-pressure: held stable, no new command accepted
        rsp_ready = 1'b0;
        cfg_base = done_pulses; cfg_mode = 0; cfg_wait = 0; cfg_rty_n = 0;
        wb_dat_i = 32'h55AA_55AA;
        send_cmd(1'b0, 32'h0000_0800, 32'h0, 4'hF, ok);
        if (ok) begin
            wait_rsp("stall", lat, ok);
            if (ok) begin
                hold_dat = rsp_dat;
                chk("stall rsp_dat", 64'(hold_dat), 64'h55AA_55AA);
                wb_dat_i = 32'h0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall rsp_valid", 64'(rsp_valid), 64'd1);
                    chk("stall rsp_dat_hold", 64'(rsp_dat), 64'h55AA_55AA);
                    chk("stall status", 64'(rsp_status), 64'd0);
                    chk("stall cmd_ready", 64'(cmd_ready), 64'd0);
                end
                rsp_ready = 1'b1;
                @(negedge clk);
                chk("stall release rsp_valid", 64'(rsp_valid), 64'd0);
                chk("stall release cmd_ready", 64'(cmd_ready), 64'd1);
            end
        end
        rsp_ready = 1'b1;

        // Reset during an active cycle with a stalled slave
        cfg_base = done_pulses; cfg_mode = 1; cfg_wait = 0; cfg_rty_n = 0;
        send_cmd(1'b0, 32'h0000_0900, 32'h0, 4'hF, ok);
        if (ok) begin
            @(negedge clk);
            chk("midrst cyc_before", 64'(wb_cyc_o), 64'd1);
            rst = 1'b0;
            @(negedge clk);
            chk("midrst cyc", 64'(wb_cyc_o), 64'd0);
            chk("midrst stb", 64'(wb_stb_o), 64'd0);
            chk("midrst cmd_ready", 64'(cmd_ready), 64'd0);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("midrst release cmd_ready", 64'(cmd_ready), 64'd1);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
                chk("midrst cyc_idle", 64'(wb_cyc_o), 64'd0);
            end
        end
        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
